// File: rtl/clock_timekeeper.sv
// clock_timekeeper: 12-hour real-time clock feeding the 4-digit 7-segment
// display controller, with a push-button set mode (RUN -> SET_HR -> SET_MIN).
//
// Optional feature macro: CLOCK_TIMEKEEPER_DEBOUNCE_EN
//   defined   : each synchronised button passes through a db_cycles
//               stable-time debouncer before edge detection
//   undefined : two-flop synchroniser + rising-edge detect only
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   btn_mode  in   raw mode button (async, active-high)
//   btn_inc   in   raw increment button (async, active-high)
//   time_bus  out  {hour[11:8] 1..12, tenmin[7:4] 0..5, min[3:0] 0..9}
//   dp_out    out  decimal point: 1 Hz blink in RUN, steady on in set modes
//   pm        out  0 = AM, 1 = PM
//   sec_tick  out  one-cycle pulse at each one-second boundary
module clock_timekeeper #(
  parameter int unsigned sys_freq      = 100000000,
  parameter int unsigned ticks_per_sec = 100000000,
  parameter int unsigned db_cycles     = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [11:0] time_bus,
  output logic        dp_out,
  output logic        pm,
  output logic        sec_tick
);

  localparam int unsigned PRE_W = (ticks_per_sec > 1) ? $clog2(ticks_per_sec) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(ticks_per_sec - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(ticks_per_sec / 2);

  // Elaboration-time sanity check on the configuration.
  generate
    if (sys_freq == 0 || ticks_per_sec == 0 || db_cycles == 0) begin : g_bad_cfg
      $error("clock_timekeeper: sys_freq, ticks_per_sec and db_cycles must be non-zero");
    end
  endgenerate

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  // Button path: bit 0 = mode, bit 1 = inc.
  logic [1:0] btn_raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] lvl;
  logic [1:0] lvl_prev_q;
  logic       mode_p, inc_p;

  assign btn_raw = {btn_inc, btn_mode};

  // Two-flop synchroniser plus the previous-level flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_prev_q <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl;
    end
  end

`ifdef CLOCK_TIMEKEEPER_DEBOUNCE_EN
  localparam int unsigned DB_W = (db_cycles > 1) ? $clog2(db_cycles) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(db_cycles - 1);

  logic [1:0]      db_lvl_q;
  logic [DB_W-1:0] db_cnt_q [2];

  // Level follows the synchronised input only after db_cycles consecutive
  // samples that differ from the current level; any agreeing sample restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_lvl_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_lvl_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign lvl = db_lvl_q;
`else
  assign lvl = sync2_q;
`endif

  assign mode_p = lvl[0] & ~lvl_prev_q[0];
  assign inc_p  = lvl[1] & ~lvl_prev_q[1];

  // Timekeeping state.
  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0]       sec_q, sec_d;
  logic [3:0]       hour_q, hour_d;
  logic [3:0]       ten_q, ten_d;
  logic [3:0]       min_q, min_d;
  logic             pm_q, pm_d;
  logic             dp_q, dp_d;
  logic             tick_q, tick_d;

  // 12 -> 1 wrap; any illegal hour recovers to 1.
  function automatic logic [3:0] hour_next(input logic [3:0] h);
    hour_next = (h == 4'd0 || h >= 4'd12) ? 4'd1 : h + 4'd1;
  endfunction

  // Next-state logic; mode_p always takes priority over inc_p and over a
  // coincident prescaler terminal count.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    sec_d   = sec_q;
    hour_d  = hour_q;
    ten_d   = ten_q;
    min_d   = min_q;
    pm_d    = pm_q;
    tick_d  = 1'b0;
    dp_d    = dp_q;

    case (state_q)
      RUN: begin
        if (mode_p) begin
          state_d = SET_HR;
          pre_d   = '0;
          sec_d   = '0;
        end else if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          tick_d = 1'b1;
          if (sec_q >= 6'd59) begin
            sec_d = '0;
            if (min_q >= 4'd9) begin
              min_d = '0;
              if (ten_q >= 4'd5) begin
                ten_d  = '0;
                hour_d = hour_next(hour_q);
                if (hour_q == 4'd11) pm_d = ~pm_q;
              end else begin
                ten_d = ten_q + 4'd1;
              end
            end else begin
              min_d = min_q + 4'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end

      SET_HR: begin
        pre_d = '0;
        sec_d = '0;
        if (mode_p) begin
          state_d = SET_MIN;
        end else if (inc_p) begin
          hour_d = hour_next(hour_q);
          if (hour_q == 4'd11) pm_d = ~pm_q;
        end
      end

      SET_MIN: begin
        pre_d = '0;
        sec_d = '0;
        if (mode_p) begin
          state_d = RUN;
        end else if (inc_p) begin
          // Minutes wrap 59 -> 00 without touching the hour.
          if (min_q >= 4'd9) begin
            min_d = '0;
            ten_d = (ten_q >= 4'd5) ? 4'd0 : ten_q + 4'd1;
          end else begin
            min_d = min_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = RUN;
        pre_d   = '0;
        sec_d   = '0;
      end
    endcase

    // Aligned with the prescaler value that will be held next cycle.
    dp_d = (state_d == RUN) ? (pre_d < PRE_HALF) : 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pre_q   <= '0;
      sec_q   <= '0;
      hour_q  <= 4'd12;
      ten_q   <= '0;
      min_q   <= '0;
      pm_q    <= 1'b0;
      dp_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      hour_q  <= hour_d;
      ten_q   <= ten_d;
      min_q   <= min_d;
      pm_q    <= pm_d;
      dp_q    <= dp_d;
      tick_q  <= tick_d;
    end
  end

  assign time_bus = {hour_q, ten_q, min_q};
  assign pm       = pm_q;
  assign dp_out   = dp_q;
  assign sec_tick = tick_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Self-checking bench for clock_timekeeper (ticks_per_sec = 10, db_cycles = 4).
// Reference model keeps time as seconds since midnight and derives the
// 12-hour display fields arithmetically.
module tb_clock_timekeeper;

  localparam int T  = 10;
  localparam int DB = 4;
`ifdef CLOCK_TIMEKEEPER_DEBOUNCE_EN
  localparam int D = DB;
`else
  localparam int D = 0;
`endif
  localparam int HOLD = D + 2;
  localparam int GAP  = D + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_mode;
  logic        btn_inc;
  logic [11:0] time_bus;
  logic        dp_out;
  logic        pm;
  logic        sec_tick;

  clock_timekeeper #(
    .sys_freq      (100),
    .ticks_per_sec (T),
    .db_cycles     (DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .time_bus (time_bus),
    .dp_out   (dp_out),
    .pm       (pm),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int        m_t;      // seconds since midnight
  int        m_phase;  // cycles into the current second
  int        m_st;     // 0 run, 1 set hour, 2 set minutes
  bit        m_tick, m_dp;
  bit [15:0] m_hist [2];
  bit        m_lv   [2];
  bit        m_rise [2];
  bit        m_act  [2];

  typedef struct {
    int          hr_inc;
    int          min_inc;
    int          secs;
    logic [11:0] exp_bus;
    logic        exp_pm;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] bus_of(input int t);
    int h, m;
    h = (t / 3600) % 12;
    if (h == 0) h = 12;
    m = (t / 60) % 60;
    return {4'(h), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic model_reset();
    m_t = 0; m_phase = 0; m_st = 0; m_tick = 1'b0; m_dp = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_hist[b] = '0; m_lv[b] = 1'b0; m_rise[b] = 1'b0; m_act[b] = 1'b0;
    end
  endtask

  // One clock edge: button pulses arrive two sync stages (+ debounce) late.
  task automatic model_edge();
    bit raw [2];
    bit nl;
    int mm;
    raw[0] = btn_mode;
    raw[1] = btn_inc;
    for (int b = 0; b < 2; b++) begin
      m_hist[b] = {m_hist[b][14:0], raw[b]};
      m_act[b]  = m_rise[b];
      if (D == 0) begin
        nl = m_hist[b][1];
      end else begin
        nl = ~m_lv[b];
        for (int j = 2; j <= 1 + D; j++)
          if (m_hist[b][j] == m_lv[b]) nl = m_lv[b];
      end
      m_rise[b] = nl & ~m_lv[b];
      m_lv[b]   = nl;
    end
    m_tick = 1'b0;
    case (m_st)
      0: begin
        if (m_act[0]) begin
          m_st = 1; m_phase = 0; m_t = m_t - (m_t % 60);
        end else begin
          m_phase++;
          if (m_phase == T) begin
            m_phase = 0; m_tick = 1'b1; m_t = (m_t + 1) % 86400;
          end
        end
      end
      1: begin
        if (m_act[0]) m_st = 2;
        else if (m_act[1]) m_t = (m_t + 3600) % 86400;
      end
      default: begin
        if (m_act[0]) begin
          m_st = 0; m_phase = 0;
        end else if (m_act[1]) begin
          mm  = (m_t / 60) % 60;
          m_t = m_t - mm * 60 + ((mm + 1) % 60) * 60;
        end
      end
    endcase
    m_dp = (m_st == 0) ? (m_phase < T / 2) : 1'b1;
  endtask

  task automatic model_check();
    check("model {bus,pm,dp,tick}",
          32'({time_bus, pm, dp_out, sec_tick}),
          32'({bus_of(m_t), (m_t >= 43200), m_dp, m_tick}));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    model_check();
  endtask

  // b: 0 = mode, 1 = inc, 2 = both together.
  task automatic press_btn(input int b, input int hold, input int gap);
    if (b != 1) btn_mode = 1'b1;
    if (b != 0) btn_inc  = 1'b1;
    repeat (hold) step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (gap) step();
  endtask

  task automatic press(input int b);
    press_btn(b, HOLD, GAP);
  endtask

  task automatic do_reset();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check("reset time_bus", 32'(time_bus), 32'h0C00);
    check("reset pm", 32'(pm), 32'h0);
    check("reset dp_out", 32'(dp_out), 32'h0);
    check("reset sec_tick", 32'(sec_tick), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_tick(output int c);
    c = 0;
    do begin
      step();
      c++;
    end while (!sec_tick && c < 200);
  endtask

  int c;
  int r;

  initial begin
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    vecs[0] = '{3,  0,  0,   12'h300, 1'b0};
    vecs[1] = '{0,  59, 60,  12'h100, 1'b0};
    vecs[2] = '{11, 59, 60,  12'hC00, 1'b1};
    vecs[3] = '{3,  61, 0,   12'h301, 1'b0};
    vecs[4] = '{12, 0,  0,   12'hC00, 1'b1};
    vecs[5] = '{0,  9,  120, 12'hC11, 1'b0};
    vecs[6] = '{23, 0,  0,   12'hB00, 1'b1};

    @(posedge clk);
    #1;
    do_reset();

    // Free-running seconds and the first minute rollover.
    wait_tick(c);
    check("first sec_tick after reset", 32'(c), 32'(T));
    repeat (3) begin
      wait_tick(c);
      check("sec_tick period", 32'(c), 32'(T));
    end
    repeat (600 - 4 * T) step();
    check("time after 600 cycles", 32'(time_bus), 32'h0C01);

    // Increment in RUN does nothing.
    press(1);
    check("inc ignored in run", 32'(time_bus), 32'h0C01);

    // Simultaneous press: mode wins in RUN and in SET_HR.
    press(2);
    check("simultaneous in run", 32'(time_bus), 32'h0C01);
    check("dp in set_hr", 32'(dp_out), 32'h1);
    press(1);
    check("set_hr increment", 32'(time_bus), 32'h0101);
    press(2);
    check("simultaneous in set_hr", 32'(time_bus), 32'h0101);
    press(1);
    check("set_min increment", 32'(time_bus), 32'h0102);

    // Leaving SET_MIN: first tick exactly T cycles after the transition.
    btn_mode = 1'b1;
    wait_tick(c);
    check("exit to first sec_tick", 32'(c), 32'(3 + D + T));
    btn_mode = 1'b0;
    repeat (GAP) step();
    check("time after exit", 32'(time_bus), 32'h0102);

    // Increment latency in SET_HR with a 6-cycle press.
    do_reset();
    press(0);
`ifdef CLOCK_TIMEKEEPER_DEBOUNCE_EN
    btn_inc = 1'b1;
    repeat (D - 1) step();
    btn_inc = 1'b0;
    repeat (15) step();
    check("short glitch ignored", 32'(time_bus), 32'h0C00);
`endif
    btn_inc = 1'b1;
    c = 0;
    while (c < 40) begin
      if (c == 6) btn_inc = 1'b0;
      step();
      c++;
      if (time_bus !== 12'hC00) break;
    end
    btn_inc = 1'b0;
    check("inc press latency", 32'(c), 32'(3 + D));
    repeat (20) step();
    check("one inc per press", 32'(time_bus), 32'h0100);

    // Asynchronous reset from SET_MIN at 3:47.
    do_reset();
    press(0);
    repeat (3) press(1);
    press(0);
    repeat (47) press(1);
    check("time before async reset", 32'(time_bus), 32'h0347);
    #2;
    do_reset();
    wait_tick(c);
    check("run after async reset", 32'(c), 32'(T));

    // Table of set-then-run scenarios, each from reset.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      press(0);
      repeat (vecs[i].hr_inc) press(1);
      press(0);
      repeat (vecs[i].min_inc) press(1);
      press(0);
      repeat (vecs[i].secs * T + 2) step();
      check($sformatf("vec%0d time_bus", i), 32'(time_bus), 32'(vecs[i].exp_bus));
      check($sformatf("vec%0d pm", i), 32'(pm), 32'(vecs[i].exp_pm));
    end

    // Random button activity checked cycle by cycle against the model.
    do_reset();
    repeat (80) begin
      r = int'($urandom_range(0, 9));
      if (r < 2)      press_btn(0, int'($urandom_range(1, D + 4)), int'($urandom_range(1, D + 4)));
      else if (r < 6) press_btn(1, int'($urandom_range(1, D + 4)), int'($urandom_range(1, D + 4)));
      else if (r < 7) press_btn(2, int'($urandom_range(1, D + 4)), int'($urandom_range(1, D + 4)));
      else            repeat (int'($urandom_range(1, 150))) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
- Upstream time source for the four-digit 7-segment display controller.
- Counts real time in 12-hour format from the system clock. Drives the controller's 12-bit time bus {hour, tens-of-minutes, minutes} and its decimal-point input.
- Provides a three-state set mode driven by two push buttons, so the user can set hours and minutes.

Parameters:
- sys_freq, 100000000, system clock frequency in Hz (documentation only; all timing derives from ticks_per_sec).
- ticks_per_sec, 100000000, clk cycles per second; benches use 10.
- db_cycles, 1000000, debounce stable-time in clk cycles (10 ms); used only with DEBOUNCE_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_mode  input  1  raw mode button, asynchronous, active-high.
- btn_inc  input  1  raw increment button, asynchronous, active-high.
- time_bus  output  12  {hour[11:8] binary 1..12, tenmin[7:4] 0..5, min[3:0] 0..9}.
- dp_out  output  1  decimal-point drive for the display controller.
- pm  output  1  0 = AM, 1 = PM.
- sec_tick  output  1  one-cycle pulse at each one-second boundary.

Behaviour:
- Reset (async assert, sync release): time_bus = {4'd12, 4'd0, 4'd0}, pm=0, dp_out=0, sec_tick=0, state=RUN, prescaler=0, seconds=0.
- Button input path:
  - Two-flop synchroniser on each button, then rising-edge detect, giving one-cycle pulses mode_p and inc_p.
  - Latency from raw edge to pulse: 3 clk.
  - A held button produces exactly one pulse.
- Prescaler: 0..ticks_per_sec-1. At terminal count it wraps to 0 and sec_tick pulses for 1 cycle. It runs only in RUN.
- Time chain, RUN only, advanced on sec_tick:
  - seconds 0..59.
  - At 59 -> 0, min increments.
  - min 9 -> 0 carries into tenmin.
  - tenmin 5 -> 0 carries into hour.
  - hour 12 -> 1.
  - hour 11 -> 12 toggles pm.
  - All carries resolve in the same cycle. 12:59:59 -> 1:00:00 in one step.
- State machine, advanced on mode_p:
  - RUN -> SET_HR -> SET_MIN -> RUN.
- SET_HR:
  - Prescaler and seconds are held at 0.
  - inc_p increments hour 12 -> 1 -> ... -> 12, wrapping 12 -> 1. Crossing 11 -> 12 toggles pm.
  - Minutes are untouched.
- SET_MIN:
  - inc_p increments {tenmin, min} as 00..59.
  - 59 -> 00 wraps with no carry into hour.
- Exit SET_MIN -> RUN:
  - Prescaler and seconds cleared.
  - The first sec_tick occurs exactly ticks_per_sec cycles after the transition.
- RUN: inc_p is ignored.
- Simultaneous mode_p and inc_p in the same cycle: mode_p wins; inc_p is discarded.
- dp_out:
  - RUN: 1 while prescaler < ticks_per_sec/2 (integer division), else 0. This is a 1 Hz blink at roughly 50 % duty.
  - SET_HR or SET_MIN: constant 1.
- Outputs are registered; time_bus changes in the cycle after the causing event.
- Illegal internal values (hour 0 or >12, tenmin >5, min >9) are never produced. If seen, the next increment forces the field to its minimum legal value.
- rst_n asserted mid-operation: immediate return to reset values, including from either SET state.

Optional Feature:
- Macro: CLOCK_TIMEKEEPER_DEBOUNCE_EN.
- Defined:
  - Each synchronised button feeds a counter.
  - The debounced level updates only after the input has been stable for db_cycles consecutive cycles.
  - Edge detect operates on the debounced level.
  - Pulse latency is db_cycles+3 cycles.
  - Glitches shorter than db_cycles produce no pulse.
- Undefined: synchroniser plus edge detect only, as described above; db_cycles is unused.

Test Plan:
- Reset to RUN, ticks_per_sec=10: time_bus=0xC00, pm=0 at reset. sec_tick every 10 cycles. dp_out high on prescaler counts 0-4, low on 5-9. After 600 cycles, time_bus=0xC01.
- Carry: set time to 12:59, then 60 sec_ticks -> time_bus=0x100, pm unchanged. Set 11:59, then 60 ticks -> time_bus=0xC00, pm toggles 0 -> 1.
- Set mode: mode pulse, then inc x3 -> hour 12 -> 3 (0x300). Mode pulse, then inc x61 -> minutes 01 (0x301), hour not carried. Mode pulse -> RUN; first sec_tick exactly 10 cycles later. dp_out=1 throughout both SET states.
- Button in RUN and simultaneous press: inc pulse in RUN -> time_bus unchanged. mode and inc rising together in RUN -> state SET_HR, hour unchanged.
- Async reset: assert rst_n low mid-cycle while in SET_MIN with time 0x347 -> outputs at reset values immediately (before the next clk edge); state RUN after release.
- With CLOCK_TIMEKEEPER_DEBOUNCE_EN and db_cycles=4: a 3-cycle btn_inc glitch in SET_HR -> no change. A 6-cycle press -> exactly one hour increment, seen 7 cycles after the press begins.
